mul_seq_ctrl: RTL

//  Iterative multi-cycle controller/datapath for RV32M MUL, MULH, MULHSU and MULHU.

---
 rtl/mul_seq_ctrl_if.sv | 15 +
 rtl/mul_seq_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: EX-stage handshake between the pipeline and the iterative multiplier.
interface mul_seq_ctrl_if #(parameter int XLEN = 32);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, rs1, rs2, flush, input stall, busy, done, result);
    modport slave  (input start, op, rs1, rs2, flush, output stall, busy, done, result);
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: radix-2 shift-add sequencer for RV32M MUL/MULH/MULHSU/MULHU.
// Multiplies operand magnitudes over XLEN cycles, then applies the sign and picks the product half.
module mul_seq_ctrl #(
    parameter int XLEN = 32
) (
    input logic           clk,
    input logic           rst_n,
    mul_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              neg_q, neg_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] p;
    logic              rs1_neg, rs2_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            op_q     <= 2'b00;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    // lo_q starts as the multiplier and fills with product bits as it shifts out
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        op_d     = op_q;
        result_d = result_q;
        sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        prod     = {sum, lo_q[XLEN-1:1]};
        p        = neg_q ? -prod : prod;
        rs1_neg  = (bus.op[0] ^ bus.op[1]) & bus.rs1[XLEN-1];
        rs2_neg  = (bus.op == 2'b01) & bus.rs2[XLEN-1];
        if (bus.flush) begin
            state_d = IDLE;
        end else if (state_q == IDLE && bus.start) begin
            a_d     = rs1_neg ? -bus.rs1 : bus.rs1;
            lo_d    = rs2_neg ? -bus.rs2 : bus.rs2;
            hi_d    = '0;
            cnt_d   = '0;
            neg_d   = rs1_neg ^ rs2_neg;
            op_d    = bus.op;
            state_d = CALC;
        end else if (state_q == CALC) begin
            hi_d  = prod[2*XLEN-1:XLEN];
            lo_d  = prod[XLEN-1:0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN - 1)) begin
                state_d  = DONE;
                result_d = (op_q == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    assign bus.stall  = (state_q == IDLE && bus.start && !bus.flush) || (state_q == CALC);
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE) && !bus.flush;
    assign bus.result = result_q;
endmodule
